// File: rtl/rf_pkg.sv
// Shared types and default sizing for the register file bank and its clear controller.
package rf_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_e;

  localparam int unsigned RfWidthDefault = 8;
  localparam int unsigned RfDepthDefault = 32;

endpackage

// File: rtl/rf_clear_ctrl.sv
// Clear sequencer: walks PTR over every register, one per cycle, and flags BUSY meanwhile.
module rf_clear_ctrl
  import rf_pkg::*;
#(
  parameter  int unsigned DEPTH = RfDepthDefault,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CLR,
  output logic [AW-1:0] PTR,
  output logic          BUSY
);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (CLR) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        // Exit on the last index rather than relying on the pointer wrapping.
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Reset itself reads as busy so outputs are quiet before the first clear starts.
  assign BUSY = RST | (state_q == CLEAR);
  assign PTR  = ptr_q;

endmodule

// File: rtl/reg_file_bank.sv
// Two-read, one-write register file with a sequenced full clear and optional write-through.
module reg_file_bank
  import rf_pkg::*;
#(
  parameter  int unsigned WIDTH  = RfWidthDefault,
  parameter  int unsigned DEPTH  = RfDepthDefault,
  parameter  int unsigned BYPASS = 0,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic [AW-1:0]    ADRX,
  input  logic [AW-1:0]    ADRY,
  input  logic             RF_WR,
  input  logic             CLR,
  output logic [WIDTH-1:0] DX_OUT,
  output logic [WIDTH-1:0] DY_OUT,
  output logic             BUSY
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    clr_ptr;
  logic             busy;

  rf_clear_ctrl #(
    .DEPTH(DEPTH)
  ) u_clear_ctrl (
    .CLK (CLK),
    .RST (RST),
    .CLR (CLR),
    .PTR (clr_ptr),
    .BUSY(busy)
  );

  // With RST low, busy means the sequencer is in CLEAR and owns the write port.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (busy) begin
        mem_q[clr_ptr] <= '0;
      end else if (RF_WR) begin
        mem_q[ADRX] <= DIN;
      end
    end
  end

  always_comb begin
    DX_OUT = mem_q[ADRX];
    DY_OUT = mem_q[ADRY];
    if (busy) begin
      DX_OUT = '0;
      DY_OUT = '0;
    end else if ((BYPASS != 0) && RF_WR) begin
      DX_OUT = DIN;
      if (ADRY == ADRX) begin
        DY_OUT = DIN;
      end
    end
  end

  assign BUSY = busy;

endmodule

// File: tb/tb_reg_file_bank.sv
// Drives three bank configurations from shared stimulus and checks them against an array model.
module tb_reg_file_bank;

  logic        clk;
  logic        rst, clr, wr;
  logic [15:0] din;
  logic [4:0]  ax, ay;

  logic [7:0]  dx0, dy0, dx1, dy1;
  logic [15:0] dx2, dy2;
  logic        bz0, bz1, bz2;

  int unsigned vectors;
  int unsigned miscompares;

  // Model: register contents plus the number of clear cycles still to run.
  logic [7:0]  ma [32];
  logic [15:0] mb [8];
  int unsigned left_a, left_b;
  bit          mvalid;

  reg_file_bank #(.WIDTH(8), .DEPTH(32), .BYPASS(0)) u0 (
    .CLK(clk), .RST(rst), .DIN(din[7:0]), .ADRX(ax), .ADRY(ay), .RF_WR(wr), .CLR(clr),
    .DX_OUT(dx0), .DY_OUT(dy0), .BUSY(bz0)
  );

  reg_file_bank #(.WIDTH(8), .DEPTH(32), .BYPASS(1)) u1 (
    .CLK(clk), .RST(rst), .DIN(din[7:0]), .ADRX(ax), .ADRY(ay), .RF_WR(wr), .CLR(clr),
    .DX_OUT(dx1), .DY_OUT(dy1), .BUSY(bz1)
  );

  reg_file_bank #(.WIDTH(16), .DEPTH(8), .BYPASS(0)) u2 (
    .CLK(clk), .RST(rst), .DIN(din), .ADRX(ax[2:0]), .ADRY(ay[2:0]), .RF_WR(wr), .CLR(clr),
    .DX_OUT(dx2), .DY_OUT(dy2), .BUSY(bz2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      left_a <= 32;
      left_b <= 8;
      for (int i = 0; i < 32; i++) ma[i] <= '0;
      for (int i = 0; i < 8; i++) mb[i] <= '0;
      mvalid <= 1'b1;
    end else if (mvalid) begin
      if (left_a > 0) begin
        left_a <= left_a - 1;
      end else if (clr) begin
        left_a <= 32;
        for (int i = 0; i < 32; i++) ma[i] <= '0;
      end else if (wr) begin
        ma[ax] <= din[7:0];
      end
      if (left_b > 0) begin
        left_b <= left_b - 1;
      end else if (clr) begin
        left_b <= 8;
        for (int i = 0; i < 8; i++) mb[i] <= '0;
      end else if (wr) begin
        mb[ax[2:0]] <= din;
      end
    end
  end

  always @(negedge clk) begin
    logic        ba, bb;
    logic [7:0]  ex0, ey0, ex1, ey1;
    logic [15:0] ex2, ey2;
    if (rst || mvalid) begin
      ba  = rst || (left_a > 0);
      bb  = rst || (left_b > 0);
      ex0 = ba ? 8'h00 : ma[ax];
      ey0 = ba ? 8'h00 : ma[ay];
      ex1 = ba ? 8'h00 : (wr ? din[7:0] : ma[ax]);
      ey1 = ba ? 8'h00 : ((wr && ay == ax) ? din[7:0] : ma[ay]);
      ex2 = bb ? 16'h0 : mb[ax[2:0]];
      ey2 = bb ? 16'h0 : mb[ay[2:0]];
      chk("u0_busy", 16'(bz0), 16'(ba));
      chk("u0_dx", 16'(dx0), 16'(ex0));
      chk("u0_dy", 16'(dy0), 16'(ey0));
      chk("u1_busy", 16'(bz1), 16'(ba));
      chk("u1_dx", 16'(dx1), 16'(ex1));
      chk("u1_dy", 16'(dy1), 16'(ey1));
      chk("u2_busy", 16'(bz2), 16'(bb));
      chk("u2_dx", dx2, ex2);
      chk("u2_dy", dy2, ey2);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic read_all_zero(input string name);
    for (int i = 0; i < 32; i++) begin
      ax = 5'(i);
      ay = 5'(31 - i);
      @(negedge clk);
      chk(name, 16'(dx0), 16'h0);
      chk(name, 16'(dy0), 16'h0);
      cyc();
    end
  endtask

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    mvalid      = 1'b0;
    rst = 1'b1; clr = 1'b0; wr = 1'b0; din = '0; ax = '0; ay = '0;

    // Reset: one cycle of RST, then exactly 32 busy cycles and an all-zero file.
    cyc();
    rst = 1'b0;
    n = 0;
    while (bz0 && n < 100) begin n++; cyc(); end
    chk("reset_busy_len", 16'(n), 16'd32);
    read_all_zero("reset_read_zero");

    // Fill reg[i] = i, read back crosswise.
    for (int i = 0; i < 32; i++) begin
      wr = 1'b1; ax = 5'(i); din = 16'(i);
      cyc();
    end
    wr = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ax = 5'(i);
      ay = 5'(31 - i);
      @(negedge clk);
      chk("fill_dx", 16'(dx0), 16'(i));
      chk("fill_dy", 16'(dy0), 16'(31 - i));
      cyc();
    end

    // Bypass vs. no bypass on address 5 (holds 5).
    wr = 1'b1; ax = 5'd5; ay = 5'd5; din = 16'h00A5;
    @(negedge clk);
    chk("byp1_dx", 16'(dx1), 16'h00A5);
    chk("byp1_dy", 16'(dy1), 16'h00A5);
    chk("byp0_dx_old", 16'(dx0), 16'h0005);
    chk("byp0_dy_old", 16'(dy0), 16'h0005);
    cyc();
    wr = 1'b0;
    @(negedge clk);
    chk("byp0_dx_new", 16'(dx0), 16'h00A5);
    cyc();

    // Clear colliding with a write, then writes attempted during busy.
    wr = 1'b1; clr = 1'b1; ax = 5'd7; din = 16'h003C;
    cyc();
    clr = 1'b0;
    n = 0;
    while (bz0 && n < 100) begin
      wr = 1'b1; ax = 5'($urandom); din = 16'($urandom);
      n++;
      cyc();
    end
    wr = 1'b0;
    chk("clr_busy_len", 16'(n), 16'd32);
    ax = 5'd7;
    @(negedge clk);
    chk("clr_reg7_zero", 16'(dx0), 16'h0);
    cyc();
    read_all_zero("clr_no_write");

    // Reset in the middle of a clear restarts it; CLR pulses are ignored.
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    repeat (10) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n = 0;
    while (bz0 && n < 100) begin
      clr = 1'($urandom_range(0, 1));
      n++;
      cyc();
    end
    clr = 1'b0;
    chk("midrst_busy_len", 16'(n), 16'd32);
    repeat (40) cyc();

    // Narrow/wide configuration: WIDTH=16, DEPTH=8.
    wr = 1'b1; ax = 5'd7; din = 16'hBEEF;
    cyc();
    wr = 1'b0;
    @(negedge clk);
    chk("sweep_read", dx2, 16'hBEEF);
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    n = 0;
    while (bz2 && n < 100) begin n++; cyc(); end
    chk("sweep_busy_len", 16'(n), 16'd8);
    repeat (40) cyc();

    // Random traffic against the model.
    repeat (3000) begin
      rst = ($urandom_range(0, 199) == 0);
      clr = ($urandom_range(0, 39) == 0);
      wr  = 1'($urandom_range(0, 1));
      din = 16'($urandom);
      ax  = 5'($urandom);
      ay  = ($urandom_range(0, 3) == 0) ? ax : 5'($urandom);
      cyc();
    end
    rst = 1'b0; clr = 1'b0; wr = 1'b0;
    repeat (5) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file_bank.md
REG_FILE_BANK -- requirements
Module: reg_file_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data bits per register.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning number of registers (power of two, 2..256).
REQ-003 The block SHALL have parameter BYPASS, default 0, meaning 1 = write-through forwarding on read ports.
REQ-004 The block SHALL have derived constant AW = clog2(DEPTH), meaning address width.
REQ-005 The block SHALL have port CLK, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port RST, input, 1, meaning reset, synchronous and active-high.
REQ-007 The block SHALL have port DIN, input, WIDTH, meaning write data.
REQ-008 The block SHALL have port ADRX, input, AW, meaning read port X address and the write address.
REQ-009 The block SHALL have port ADRY, input, AW, meaning read port Y address.
REQ-010 The block SHALL have port RF_WR, input, 1, meaning write enable.
REQ-011 The block SHALL have port CLR, input, 1, meaning request a full clear of all registers.
REQ-012 The block SHALL have port DX_OUT, output, WIDTH, meaning read data for ADRX.
REQ-013 The block SHALL have port DY_OUT, output, WIDTH, meaning read data for ADRY.
REQ-014 The block SHALL have port BUSY, output, 1, meaning a clear sequence is in progress.

Function
REQ-015 Reads SHALL be combinational: DX_OUT = reg[ADRX] and DY_OUT = reg[ADRY], with zero latency.
REQ-016 When RF_WR=1, BUSY=0 and RST=0, reg[ADRX] SHALL take DIN at the rising edge, visible on the reads from that edge.
REQ-017 With BYPASS=1 and RF_WR=1 and BUSY=0, DX_OUT SHALL equal DIN in the same cycle.
REQ-018 With BYPASS=1 and RF_WR=1 and BUSY=0, DY_OUT SHALL equal DIN in the same cycle when ADRY==ADRX.
REQ-019 With BYPASS=0, no forwarding SHALL occur and the old value SHALL be read until the edge.
REQ-020 The FSM SHALL have exactly two states, IDLE and CLEAR, with a clear pointer PTR of AW bits.
REQ-021 In IDLE, when CLR=1 at an edge, the FSM SHALL set PTR to 0 and enter CLEAR.
REQ-022 In CLEAR, each edge SHALL zero reg[PTR] and increment PTR.
REQ-023 In CLEAR, the edge that zeroes reg[DEPTH-1] SHALL move the FSM to IDLE, so CLEAR lasts exactly DEPTH cycles.
REQ-024 BUSY SHALL be 1 exactly while the FSM is in CLEAR.
REQ-025 While BUSY=1, RF_WR SHALL be ignored, with no write and no forwarding, and the dropped write is not queued.
REQ-026 While BUSY=1, DX_OUT and DY_OUT SHALL both be driven to 0.
REQ-027 CLR asserted while in CLEAR SHALL be ignored and SHALL not restart the sequence.
REQ-028 If CLR=1 and RF_WR=1 in the same IDLE cycle, the write SHALL complete at that edge and be erased later by the clear.
REQ-029 PTR wrap SHALL not be relied upon; the exit from CLEAR is decided by PTR==DEPTH-1.
REQ-030 ADRX and ADRY SHALL be any value in 0..DEPTH-1, and all registers, including address 0, SHALL be writable.

Reset
REQ-031 RST=1 at an edge SHALL force state CLEAR with PTR=0, regardless of the current state, including mid-clear (restarts from 0).
REQ-032 RST SHALL take priority over CLR and RF_WR.
REQ-033 After RST deasserts, BUSY SHALL remain 1 for DEPTH cycles, then every register SHALL read 0.
REQ-034 Output values while RST=1 SHALL be BUSY=1, DX_OUT=0 and DY_OUT=0.

Structure
REQ-035 A shared package rf_pkg SHALL hold the state enum (IDLE, CLEAR) and the default WIDTH/DEPTH constants.
REQ-036 The storage SHALL be a flop array inside reg_file_bank.
REQ-037 The clear FSM SHALL be one natural sub-module, rf_clear_ctrl, with ports CLK, RST, CLR, PTR, BUSY, parametrised by DEPTH.
REQ-038 Only the read multiplexers and the bypass logic SHALL be combinational.

Verification
REQ-039 A bench SHALL cover reset: RST for 1 cycle -> BUSY high for exactly 32 cycles (default), then reading every ADRX/ADRY returns 0.
REQ-040 A bench SHALL cover fill: write reg[i]=i for i=0..31 -> reads with ADRX=i, ADRY=31-i return i and 31-i.
REQ-041 A bench SHALL cover bypass: BYPASS=1, RF_WR=1, ADRX=ADRY=5, DIN=0xA5 -> DX_OUT=DY_OUT=0xA5 before the edge; with BYPASS=0 -> old value until the edge.
REQ-042 A bench SHALL cover clear/write collision: CLR with a write of 0x3C to reg 7 in the same cycle, then RF_WR during BUSY -> BUSY 32 cycles, reg 7 reads 0 afterwards, no write lands.
REQ-043 A bench SHALL cover mid-clear reset: RST at cycle 10 of CLEAR -> BUSY stays high 32 more cycles, and CLR pulses during BUSY have no effect.
REQ-044 A bench SHALL cover the parameter sweep WIDTH=16, DEPTH=8: write 0xBEEF to reg 7 -> reads 0xBEEF, and CLR -> BUSY lasts 8 cycles.
